mem_arbiter: RTL

- Two-port arbiter that shares the single 256-bit off-chip data memory interface between the instruction cache (port 0) and the data cache (port 1).
- Sits between both cache controllers and the memory model.
- Serializes line-fill and write-back transactions and routes each ack and read data to the granted requester.
- Includes a per-transaction watchdog that aborts hung transactions and raises a sticky error.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_sel.sv | 33 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter (icache on port 0, dcache on port 1).
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEFAULT  = 32;
    localparam int unsigned LINE_W_DEFAULT  = 256;
    localparam int unsigned TIMEOUT_DEFAULT = 1023;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner select for the memory arbiter.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise port 1 (dcache) has fixed priority.
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic p0_enable_i,
    input  logic p1_enable_i,
    input  logic last_grant_i,
    output logic req_o,
    output logic winner_o
);

`ifndef MEM_ARB_RR_EN
    // last_grant is tracked by the top but plays no part in fixed-priority selection.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

    always_comb begin
        req_o    = p0_enable_i | p1_enable_i;
        winner_o = PORT_I;
        if (p0_enable_i && p1_enable_i) begin
`ifdef MEM_ARB_RR_EN
            winner_o = ~last_grant_i;
`else
            winner_o = PORT_D;
`endif
        end else if (p1_enable_i) begin
            winner_o = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one line-wide memory interface, with a per-transaction watchdog.
// Build with MEM_ARB_RR_EN defined for round-robin arbitration (see mem_arb_sel).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned LINE_W  = LINE_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [LINE_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [LINE_W-1:0] p0_data_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [LINE_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [LINE_W-1:0] p1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

    state_e              state_q,      state_d;
    logic [TimerW-1:0]   timer_q,      timer_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_enable_q, mem_enable_d;
    logic                mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [LINE_W-1:0]   mem_data_q,   mem_data_d;
    logic                err_q,        err_d;

    logic req;
    logic winner;

    mem_arb_sel u_sel (
        .p0_enable_i  (p0_enable_i),
        .p1_enable_i  (p1_enable_i),
        .last_grant_i (last_grant_q),
        .req_o        (req),
        .winner_o     (winner)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        last_grant_d = last_grant_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        err_d        = err_q;

        case (state_q)
            StIdle: begin
                mem_enable_d = 1'b0;
                if (req) begin
                    state_d      = (winner == PORT_D) ? StGnt1 : StGnt0;
                    timer_d      = '0;
                    mem_enable_d = 1'b1;
                    mem_write_d  = (winner == PORT_D) ? p1_write_i : p0_write_i;
                    mem_addr_d   = (winner == PORT_D) ? p1_addr_i  : p0_addr_i;
                    mem_data_d   = (winner == PORT_D) ? p1_data_i  : p0_data_i;
                end
            end
            StGnt0, StGnt1: begin
                // An ack arriving in the watchdog's final cycle still completes normally.
                if (mem_ack_i) begin
                    state_d      = StIdle;
                    mem_enable_d = 1'b0;
                    last_grant_d = (state_q == StGnt1) ? PORT_D : PORT_I;
                end else if (timer_q == TimerW'(TIMEOUT)) begin
                    state_d      = StIdle;
                    mem_enable_d = 1'b0;
                    err_d        = 1'b1;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: begin
                state_d      = StIdle;
                mem_enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            last_grant_q <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            last_grant_q <= last_grant_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        p0_ack_o  = (state_q == StGnt0) && mem_ack_i;
        p1_ack_o  = (state_q == StGnt1) && mem_ack_i;
        p0_data_o = (state_q == StGnt0) ? mem_data_i : '0;
        p1_data_o = (state_q == StGnt1) ? mem_data_i : '0;
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q != StIdle);

endmodule
